// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM pipeline stage.
// Optional alignment checking is enabled with MEM_ALIGN_CHECK_EN.
package mem_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_RD_W = 5;
    localparam int WORD_ALIGN_BITS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_access_stage_mem_req_fsm.sv
// Data-memory request sequencer: owns the req/ack handshake and stall.
// MEM_ALIGN_CHECK_EN makes misaligned memops retire as bubbles.
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall,
    output logic              idle,
    output logic              done,
    output logic              mem_misalign
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        ~ADDR_W'((1 << WORD_ALIGN_BITS) - 1);

    mem_state_t state;
    logic       memop;
    logic       misaligned;

    assign memop = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |alu_out[WORD_ALIGN_BITS-1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign idle  = (state == IDLE);
    assign done  = (state == WAIT) && dmem_ack;
    assign stall = (idle && memop && !misaligned)
                 || ((state == WAIT) && !dmem_ack);

    // A store wins when both read and write are flagged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            mem_misalign <= 1'b0;
        end else begin
            mem_misalign <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (memop) begin
                        if (misaligned) begin
                            mem_misalign <= 1'b1;
                        end else begin
                            state      <= WAIT;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= alu_out[ADDR_W-1:0] & ALIGN_MASK;
                            dmem_wdata <= store_data;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: XM_* register in, MW_* register out, dmem handshake.
// Build with MEM_ALIGN_CHECK_EN to trap misaligned loads/stores.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RD_W-1:0]   XM_RD,
    input  logic [DATA_W-1:0] ALUout,
    input  logic              XM_RegWrite,
    input  logic              XM_MemRead,
    input  logic              XM_MemWrite,
    input  logic [DATA_W-1:0] XM_StoreData,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic [RD_W-1:0]   MW_RD,
    output logic [DATA_W-1:0] MW_WBData,
    output logic              MW_RegWrite,
    output logic              mem_misalign
);

    logic memop;
    logic idle;
    logic done;

    assign memop = XM_MemRead | XM_MemWrite;

    mem_req_fsm #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (XM_MemRead),
        .mem_write   (XM_MemWrite),
        .alu_out     (ALUout),
        .store_data  (XM_StoreData),
        .dmem_ack    (dmem_ack),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .stall       (stall),
        .idle        (idle),
        .done        (done),
        .mem_misalign(mem_misalign)
    );

    // Issue, wait, store-retire and misaligned ops all leave a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            MW_RD       <= '0;
            MW_WBData   <= '0;
            MW_RegWrite <= 1'b0;
        end else if (idle && !memop) begin
            MW_RD       <= XM_RD;
            MW_WBData   <= ALUout;
            MW_RegWrite <= XM_RegWrite;
        end else if (done && !dmem_we) begin
            MW_RD       <= XM_RD;
            MW_WBData   <= dmem_rdata;
            MW_RegWrite <= XM_RegWrite;
        end else begin
            MW_RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage with a behavioural memory model.
// Compile with MEM_ALIGN_CHECK_EN to exercise the misalignment trap.
module tb_memory_access_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [RW-1:0] XM_RD = '0;
    logic [DW-1:0] ALUout = '0;
    logic          XM_RegWrite = 1'b0;
    logic          XM_MemRead = 1'b0;
    logic          XM_MemWrite = 1'b0;
    logic [DW-1:0] XM_StoreData = '0;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic          ack_resp = 1'b0;
    logic          stray_ack = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          stall;
    logic [RW-1:0] MW_RD;
    logic [DW-1:0] MW_WBData;
    logic          MW_RegWrite;
    logic          mem_misalign;

    assign dmem_ack = ack_resp | stray_ack;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk         (clk),
        .rst         (rst),
        .XM_RD       (XM_RD),
        .ALUout      (ALUout),
        .XM_RegWrite (XM_RegWrite),
        .XM_MemRead  (XM_MemRead),
        .XM_MemWrite (XM_MemWrite),
        .XM_StoreData(XM_StoreData),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .stall       (stall),
        .MW_RD       (MW_RD),
        .MW_WBData   (MW_WBData),
        .MW_RegWrite (MW_RegWrite),
        .mem_misalign(mem_misalign)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

    int checks = 0;
    int failures = 0;
    int next_delay = 0;
    int exp_misalign = 0;
    int seen_misalign = 0;

    req_t req_q[$];
    wb_t  wb_q[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] resp_mem[logic [AW-1:0]];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory responder: acks each request after next_delay WAIT cycles.
    initial begin
        int w;
        int d;
        forever begin
            @(negedge clk);
            ack_resp = 1'b0;
            if (dmem_req === 1'b1 && rst) begin
                d = next_delay;
                w = 0;
                while (w < d && dmem_req === 1'b1) begin
                    @(negedge clk);
                    w++;
                end
                if (dmem_req === 1'b1) begin
                    if (dmem_we)
                        resp_mem[dmem_addr] = dmem_wdata;
                    else if (resp_mem.exists(dmem_addr))
                        dmem_rdata = resp_mem[dmem_addr];
                    else
                        dmem_rdata = init_word(dmem_addr);
                    ack_resp = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expected requests and writebacks as the DUT shows them.
    initial begin
        logic prev_req;
        req_t e;
        wb_t  ew;
        prev_req = 1'b0;
        e = '{1'b0, '0, '0};
        forever begin
            @(negedge clk);
            if (dmem_req === 1'b1 && !prev_req) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=addr %h required=none", dmem_addr);
                end else begin
                    e = req_q.pop_front();
                    chk("req_we", dmem_we, e.we);
                    chk("req_addr", dmem_addr, e.addr);
                    chk("req_wdata", dmem_wdata, e.wdata);
                end
            end else if (dmem_req === 1'b1) begin
                chk("hold_we", dmem_we, e.we);
                chk("hold_addr", dmem_addr, e.addr);
                chk("hold_wdata", dmem_wdata, e.wdata);
            end
            if (MW_RegWrite === 1'b1) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wb actual=rd %0d required=none", MW_RD);
                end else begin
                    ew = wb_q.pop_front();
                    chk("wb_rd", MW_RD, ew.rd);
                    chk("wb_data", MW_WBData, ew.data);
                end
            end
            if (mem_misalign === 1'b1) seen_misalign++;
            prev_req = (dmem_req === 1'b1);
        end
    end

    // Present one op from a negedge and hold it until it advances.
    task automatic issue(input logic [RW-1:0] rd, input logic [DW-1:0] alu,
                         input logic [DW-1:0] sd, input logic rw,
                         input logic mr, input logic mw, input int d);
        int n;
        logic memop;
        logic mis;
        logic [AW-1:0] a;
        req_t r;
        wb_t  w;
        memop = mr | mw;
        a = alu & ~32'h3;
`ifdef MEM_ALIGN_CHECK_EN
        mis = memop && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (mis) begin
            exp_misalign++;
        end else if (memop) begin
            r.we = mw;
            r.addr = a;
            r.wdata = sd;
            req_q.push_back(r);
            if (mw) begin
                ref_mem[a] = sd;
            end else if (rw) begin
                w.rd = rd;
                w.data = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                wb_q.push_back(w);
            end
        end else if (rw) begin
            w.rd = rd;
            w.data = alu;
            wb_q.push_back(w);
        end
        next_delay = d;
        XM_RD = rd;
        ALUout = alu;
        XM_StoreData = sd;
        XM_RegWrite = rw;
        XM_MemRead = mr;
        XM_MemWrite = mw;
        n = 0;
        #1;
        while (stall !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
            #1;
        end
        chk("stall_cycles", n, (memop && !mis) ? d + 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] sd;
        logic          rw;
        int            kind;

        repeat (3) @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_mw_rd", MW_RD, 0);
        chk("rst_mw_data", MW_WBData, 0);
        chk("rst_mw_we", MW_RegWrite, 0);
        chk("rst_misalign", mem_misalign, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b1;
        ref_mem[32'h40] = 32'hDEADBEEF;
        resp_mem[32'h40] = 32'hDEADBEEF;
        @(negedge clk);

        issue(5'd8, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 0);
        chk("pass_data", MW_WBData, 32'h1234);
        issue(5'd9, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 3);
        chk("load_data", MW_WBData, 32'hDEADBEEF);
        issue(5'd3, 32'h80, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 0);
        chk("store_no_wb", MW_RegWrite, 0);
        issue(5'd4, 32'hC0, 32'h11112222, 1'b1, 1'b1, 1'b1, 1);

        stray_ack = 1'b1;
        issue(5'd5, 32'h5555, 32'h0, 1'b1, 1'b0, 1'b0, 0);
        stray_ack = 1'b0;
        chk("stray_ack_pass", MW_WBData, 32'h5555);

        issue(5'd6, 32'h42, 32'h0, 1'b1, 1'b1, 1'b0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_pulse", mem_misalign, 1);
        chk("misalign_bubble", MW_RegWrite, 0);
`else
        chk("misalign_tied", mem_misalign, 0);
`endif
        issue(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
        chk("misalign_drop", mem_misalign, 0);

        next_delay = 100;
        XM_RD = 5'd7;
        ALUout = 32'h100;
        XM_StoreData = 32'h0;
        XM_RegWrite = 1'b1;
        XM_MemRead = 1'b1;
        XM_MemWrite = 1'b0;
        req_q.push_back('{1'b0, 32'h100, 32'h0});
        repeat (2) @(negedge clk);
        chk("wait_stall", stall, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req", dmem_req, 0);
        chk("midrst_mw_rd", MW_RD, 0);
        chk("midrst_mw_data", MW_WBData, 0);
        chk("midrst_mw_we", MW_RegWrite, 0);
        XM_RegWrite = 1'b0;
        XM_MemRead = 1'b0;
        #1;
        chk("midrst_idle", stall, 0);
        rst = 1'b1;
        @(negedge clk);
        issue(5'd10, 32'h777, 32'h0, 1'b1, 1'b0, 1'b0, 0);
        chk("post_rst_pass", MW_WBData, 32'h777);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            rd = RW'($urandom);
            sd = $urandom;
            rw = 1'($urandom);
            alu = 32'h100 + (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) alu[1:0] = 2'($urandom_range(1, 3));
            unique case (kind)
                0: issue(rd, $urandom, sd, rw, 1'b0, 1'b0, 0);
                1: issue(rd, alu, sd, rw, 1'b1, 1'b0, $urandom_range(0, 3));
                2: issue(rd, alu, sd, rw, 1'b0, 1'b1, $urandom_range(0, 3));
                default: issue(rd, alu, sd, rw, 1'b1, 1'b1, $urandom_range(0, 3));
            endcase
        end

        XM_RegWrite = 1'b0;
        XM_MemRead = 1'b0;
        XM_MemWrite = 1'b0;
        repeat (4) @(negedge clk);
        chk("wb_drained", wb_q.size(), 0);
        chk("req_drained", req_q.size(), 0);
        chk("misalign_count", seen_misalign, exp_misalign);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
